// File: rtl/encoder.sv
// Shift-chain return path: packs SHIFT_TAIL bits MSB-first into bytes and
// queues them in a small FIFO for the UART transmitter (valid/ready).
module encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SYNC,
  input  logic       SHIFT_ENABLE,
  input  logic       SHIFT_TAIL,
  input  logic       UART_READY,
  output logic       OUT_VALID,
  output logic [7:0] OUT_DATA,
  output logic       OVERFLOW
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [2:0]       bit_cnt_reg;
  logic [6:0]       partial_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;
  logic [7:0]       mem [FIFO_DEPTH];

  logic       capture;
  logic       byte_done;
  logic [7:0] new_byte;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       drop;

  // SYNC overrides any capture on the same edge.
  assign capture   = SHIFT_ENABLE && !SYNC;
  assign byte_done = capture && (bit_cnt_reg == 3'd7);
  assign new_byte  = {partial_reg, SHIFT_TAIL};

  assign fifo_full = (count_reg == DEPTH_C);
  assign pop       = OUT_VALID && UART_READY;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push      = byte_done && (!fifo_full || pop);
  assign drop      = byte_done && fifo_full && !pop;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt_reg  <= '0;
      partial_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (SYNC) begin
        bit_cnt_reg <= '0;
        partial_reg <= '0;
      end else if (capture) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        partial_reg <= {partial_reg[5:0], SHIFT_TAIL};
      end
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr_reg] <= new_byte;
  end

  assign OUT_VALID = (count_reg != '0);
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr_reg] : 8'h00;
  assign OVERFLOW  = overflow_reg;

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: stimulus queues expected bytes, a negedge
// monitor checks every handshake and the hold-while-stalled rule.
module tb_encoder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SYNC;
  logic       SHIFT_ENABLE;
  logic       SHIFT_TAIL;
  logic       UART_READY;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       OVERFLOW;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  encoder #(.FIFO_DEPTH(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SYNC(SYNC),
    .SHIFT_ENABLE(SHIFT_ENABLE),
    .SHIFT_TAIL(SHIFT_TAIL),
    .UART_READY(UART_READY),
    .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Monitor: each accepted byte must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!OUT_VALID || OUT_DATA != prev_data) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%02h required valid=1 data=%02h",
                   OUT_VALID, OUT_DATA, prev_data);
        end
      end
      if (!OUT_VALID) begin
        checks++;
        if (OUT_DATA != 8'h00) begin
          errors++;
          $display("FAIL idle_data: got %02h required 00", OUT_DATA);
        end
      end else if (UART_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h required none", OUT_DATA);
        end else begin
          logic [7:0] exp_b;
          exp_b = sb.pop_front();
          if (OUT_DATA != exp_b) begin
            errors++;
            $display("FAIL byte: got %02h required %02h", OUT_DATA, exp_b);
          end else begin
            $display("pop %02h ok at %0t", OUT_DATA, $time);
          end
        end
      end
      prev_valid = OUT_VALID;
      prev_ready = UART_READY;
      prev_data  = OUT_DATA;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask

  task automatic shift_bit(input logic b);
    SHIFT_ENABLE = 1'b1;
    SHIFT_TAIL   = b;
    tick();
    SHIFT_ENABLE = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] v, input bit expect_out);
    for (int i = 7; i >= 0; i--)
      shift_bit(v[i]);
    if (expect_out)
      sb.push_back(v);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      tick();
    tick();
    chk(name, sb.size(), 0);
    chk({name, "_idle"}, OUT_VALID, 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    sb.delete();
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 8'h00);
    chk("rst_ovf", OVERFLOW, 0);
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; SYNC = 1'b0; SHIFT_ENABLE = 1'b0; SHIFT_TAIL = 1'b0; UART_READY = 1'b0;
    // Reset with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      SYNC = 1'($urandom); SHIFT_ENABLE = 1'($urandom);
      SHIFT_TAIL = 1'($urandom); UART_READY = 1'($urandom);
      tick();
      chk("reset_valid", OUT_VALID, 0);
      chk("reset_data", OUT_DATA, 8'h00);
      chk("reset_ovf", OVERFLOW, 0);
    end
    SYNC = 1'b0; SHIFT_ENABLE = 1'b0; UART_READY = 1'b1;
    RST_N = 1'b1;
    tick();

    // A5: visible exactly one cycle, right after the 8th capture
    shift_byte(8'hA5, 1'b1);
    chk("a5_valid", OUT_VALID, 1);
    chk("a5_data", OUT_DATA, 8'hA5);
    tick();
    chk("a5_one_cycle", OUT_VALID, 0);
    wait_drain("a5_drain");

    // Framing: partial byte discarded by SYNC, then SYNC colliding with a capture
    SYNC = 1'b1; tick(); SYNC = 1'b0;
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
    SYNC = 1'b1; tick(); SYNC = 1'b0;
    shift_byte(8'h3C, 1'b1);
    wait_drain("sync_3c");
    SYNC = 1'b1; SHIFT_ENABLE = 1'b1; SHIFT_TAIL = 1'b1; tick();
    SYNC = 1'b0; SHIFT_ENABLE = 1'b0;
    shift_byte(8'h5A, 1'b1);
    wait_drain("sync_collide");

    // Gapped shifting
    begin
      logic [7:0] v;
      v = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
        shift_bit(v[i]);
        if (i > 0) begin
          chk("gap_no_early", OUT_VALID, 0);
          for (int g = $urandom_range(0, 5); g > 0; g--)
            tick();
        end
      end
      sb.push_back(v);
    end
    wait_drain("gap_c3");

    // Backpressure
    UART_READY = 1'b0;
    shift_byte(8'h01, 1'b1);
    shift_byte(8'h02, 1'b1);
    shift_byte(8'h03, 1'b1);
    chk("bp_valid", OUT_VALID, 1);
    chk("bp_head", OUT_DATA, 8'h01);
    UART_READY = 1'b1;
    tick(); tick();
    chk("bp_third", OUT_DATA, 8'h03);
    tick();
    chk("bp_empty", OUT_VALID, 0);
    wait_drain("bp_drain");

    // Overflow: fifth byte dropped while stalled
    UART_READY = 1'b0;
    for (int k = 0; k < 4; k++)
      shift_byte(8'h10 + 8'(k), 1'b1);
    chk("ovf_before", OVERFLOW, 0);
    shift_byte(8'h14, 1'b0);
    chk("ovf_set", OVERFLOW, 1);
    UART_READY = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", OVERFLOW, 1);

    // Overflow averted by a pop on the fifth push edge
    do_reset();
    UART_READY = 1'b0;
    for (int k = 0; k < 4; k++)
      shift_byte(8'h10 + 8'(k), 1'b1);
    sb.push_back(8'h14);
    for (int i = 7; i >= 1; i--)
      shift_bit(1'(8'h14 >> i));
    UART_READY = 1'b1;
    shift_bit(1'b0);
    wait_drain("full_pop_drain");
    chk("full_pop_ovf", OVERFLOW, 0);

    // Reset mid-operation: two bytes queued and a partial byte in flight
    UART_READY = 1'b0;
    shift_byte(8'h31, 1'b1);
    shift_byte(8'h32, 1'b1);
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    do_reset();
    UART_READY = 1'b1;
    shift_byte(8'hFF, 1'b1);
    chk("post_rst_ff", OUT_DATA, 8'hFF);
    wait_drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder.md
# encoder

Return path of the serial test shift chain. Samples the chain's tail bit on every shift cycle, packs each eight consecutive bits into a byte (first bit = MSB), and buffers completed bytes in a small FIFO. It presents the bytes to the UART transmitter with a valid/ready handshake. It sits between the shift chain's SHIFT_TAIL and the UART transmit port, alongside the receive-side decoder that drives the chain head.

## Interface
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- CLK  input  1  design clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SYNC  input  1  single-cycle pulse (tied to UART IN_VALID); realigns byte framing.
- SHIFT_ENABLE  input  1  chain shift strobe; SHIFT_TAIL is sampled on each edge where it is high.
- SHIFT_TAIL  input  1  serial bit returning from the end of the chain.
- UART_READY  input  1  transmitter can accept a byte this cycle.
- OUT_VALID  output  1  OUT_DATA holds a byte for the transmitter.
- OUT_DATA  output  8  byte at FIFO head; 8'h00 when FIFO is empty.
- OVERFLOW  output  1  sticky flag: a completed byte was dropped because the FIFO was full.

## Operation
- Assembler:
  - 3-bit bit counter plus 7-bit partial shift register.
  - On each edge with SHIFT_ENABLE=1 and SYNC=0, the partial register shifts left with SHIFT_TAIL entering the LSB, and the counter increments.
  - When counter==7 and a capture occurs, the byte {partial[6:0], SHIFT_TAIL} is pushed on that same edge and the counter wraps to 0.
- SYNC=1 clears the counter and partial register. A simultaneous SHIFT_ENABLE capture is discarded, so SYNC wins. A partial byte in progress is lost and no FIFO write occurs.
- FIFO:
  - Circular buffer, FIFO_DEPTH×8, with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop occurs on an edge where OUT_VALID=1 and UART_READY=1.
- Full handling: a push while full with no simultaneous pop drops the new byte, leaves the FIFO unchanged, and sets OVERFLOW. A push while full with a simultaneous pop is accepted.
- Handshake:
  - OUT_VALID = (count != 0).
  - While OUT_VALID=1 and UART_READY=0, OUT_DATA holds stable.
  - OUT_VALID never deasserts without a pop.
- OVERFLOW clears only on reset.
- States: assembler phase = counter value 0..7. FIFO states are EMPTY / PARTIAL / FULL, derived from count.
- Reset mid-operation (RST_N low at any time) immediately forces:
  - counter 0, partial 0, pointers and count 0;
  - OUT_VALID 0, OUT_DATA 8'h00, OVERFLOW 0.
- Release of RST_N must be synchronized externally to CLK.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=8'h00, OVERFLOW=0.
- Capture to availability: the byte is written on the 8th capture edge, and OUT_VALID=1 is visible after that edge (1-cycle latency). OUT_DATA is valid in the same cycle.
- Pop edge: OUT_VALID/OUT_DATA reflect the next entry after the edge, or 0/8'h00 if the FIFO is now empty.
- Back-to-back: with UART_READY held at 1, one byte per cycle drains. A byte written into an empty FIFO cannot be popped on its own write edge.
- SHIFT_ENABLE may be high every cycle; maximum input rate is one byte per 8 cycles, so FIFO_DEPTH only absorbs UART stalls.
- OVERFLOW sets on the dropping edge, visible the following cycle.

## Test plan
- Reset: hold RST_N=0 with random inputs → OUT_VALID=0, OUT_DATA=8'h00, OVERFLOW=0. Release, then shift 8 bits 1,0,1,0,0,1,0,1 with UART_READY=1 → OUT_VALID high for exactly one cycle with OUT_DATA=8'hA5, starting the cycle after the 8th capture.
- Framing: SYNC pulse, 3 capture cycles, then SYNC again, then 8 bits of 8'h3C → exactly one byte, 8'h3C. SYNC coincident with SHIFT_ENABLE → that bit is ignored.
- Gapped shifting: bits of 8'hC3 with SHIFT_ENABLE low for random 0–5 cycles between bits → single byte 8'hC3. No output before the 8th bit.
- Backpressure: UART_READY=0 while pushing 8'h01, 8'h02, 8'h03 → OUT_VALID=1 and OUT_DATA=8'h01 stable throughout. Raise UART_READY → pops 01, 02, 03 on consecutive cycles, then OUT_VALID=0.
- Overflow: UART_READY=0 and push 5 bytes 8'h10..8'h14 (FIFO_DEPTH=4) → OVERFLOW=1 after the 5th. Drain yields 10, 11, 12, 13; OVERFLOW stays 1. Repeat with a pop coincident with the 5th push → all five bytes delivered, OVERFLOW=0.
- Reset mid-operation: assert RST_N=0 after 4 bits with 2 bytes queued → outputs return to reset values immediately. After release, 8 bits of 8'hFF yield exactly one byte, 8'hFF.
